k2_exec_ctrl: RTL
=================

// Module: k2_exec_ctrl
// PURPOSE
//  Run/step/halt sequencer for the K2 8-bit core. Gates the core step enable (core_en) and pulses
//  core_clear before a fresh run. Loads program bytes into instruction memory through a valid/ready
//  command port. Stops execution on a host HALT, a PC breakpoint, a self-loop jump (J=1, target==PC)
//  or a watchdog limit. Sits between the host/debug interface and the K2 core + program memory.
// PARAMETERS
//  ADDR_W      8   PC / imem address width
//  CYC_W       16  cycle counter width (saturating)
//  WDOG_LIMIT  0   core_en cycles before forced halt; 0 = watchdog disabled
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        asynchronous, active-high; returns block to IDLE
//  cmd_valid   in   1        host command valid
//  cmd_ready   out  1        command accepted when cmd_valid & cmd_ready at a rising edge
//  cmd_op      in   2        0=RUN 1=STEP 2=HALT 3=LOAD
//  cmd_addr    in   ADDR_W   LOAD address
//  cmd_data    in   8        LOAD instruction byte
//  cmd_err     out  1        1-cycle pulse: accepted command illegal in current state (dropped)
//  imem_we     out  1        1-cycle write strobe to program memory
//  imem_waddr  out  ADDR_W   registered write address
//  imem_wdata  out  8        registered write data
//  core_pc     in   ADDR_W   current core PC
//  core_instr  in   8        instruction at core_pc {J,C,D1,D0,Sreg,data[2:0]}
//  core_en     out  1        core may update PC/registers/carry this cycle
//  core_clear  out  1        1-cycle synchronous clear of core state (PC, RA, RB, R0, carry)
//  bp_en       in   1        breakpoint enable
//  bp_addr     in   ADDR_W   breakpoint PC
//  running     out  1        state==RUN
//  halted      out  1        state==HALTED
//  halt_cause  out  2        0=HOST 1=BREAK 2=SELFLOOP 3=WDOG; valid while halted
//  done_irq    out  1        1-cycle pulse on entry to HALTED
//  cycle_count out  CYC_W    core_en cycles since last core_clear, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1; cycle_count=0; bp_skip=0.
//  States: IDLE, CLEAR, RUN, STEP, HALTED. cmd_ready=1 in IDLE/RUN/HALTED, 0 in CLEAR/STEP.
//  IDLE: LOAD -> imem_we/addr/data next cycle, stay. RUN|STEP -> CLEAR (target latched). HALT -> cmd_err.
//  CLEAR: core_clear=1, core_en=0, cycle_count<=0; next = latched target (RUN or STEP).
//  RUN: core_en = ~stop (combinational). stop priority, highest first:
//    accepted HALT (cause HOST) > bp_en & core_pc==bp_addr & ~bp_skip (BREAK)
//    > core_instr[7] & {5'b0,core_instr[2:0]}==core_pc (SELFLOOP)
//    > WDOG_LIMIT!=0 & cycle_count==WDOG_LIMIT (WDOG).
//    On stop: core_en=0 that cycle (stopping instruction NOT executed); next=HALTED.
//    RUN/STEP/LOAD accepted while in RUN -> cmd_err, ignored.
//  STEP: core_en=1 for exactly one cycle, no stop checks; next=HALTED, halt_cause=HOST.
//  HALTED: RUN -> RUN direct (no clear); bp_skip=1 for the first RUN cycle only.
//    STEP -> STEP. LOAD -> write + state IDLE (next run starts with clear). HALT -> cmd_err.
//  cycle_count increments on every core_en=1 cycle; saturates; cleared only in CLEAR.
//  done_irq asserted in the first cycle state==HALTED. halt_cause holds until the next RUN/STEP.
//  Reset mid-RUN: core_en drops asynchronously with state; no done_irq.
//  A command is consumed on handshake only; cmd_valid with cmd_ready=0 holds until accepted.
// STRUCTURE
//  k2_pkg: state enum k2_ctrl_state_t, k2_cmd_op_t (RUN/STEP/HALT/LOAD), k2_halt_cause_t,
//    field positions K2_J_BIT=7, K2_IMM_MSB=2.
//  Sub-module k2_sat_counter #(W): clear, inc, saturating count; used for cycle_count.
//  FSM, stop-priority logic, LOAD write register and bp_skip flag live in k2_exec_ctrl.
// TESTING
//  Reset, then LOAD addr=3 data=8'hA5 -> imem_we=1 one cycle later, waddr=3, wdata=A5; state IDLE.
//  RUN from IDLE -> core_clear=1 exactly 1 cycle, core_en=1 next cycle; cycle_count counts from 0.
//  RUN, bp_en=1 bp_addr=5, PC reaches 5 -> core_en=0 that cycle, halted, cause=1, done_irq 1 pulse;
//    RUN again -> PC 5 executes (bp_skip), no immediate re-halt.
//  core_instr=8'h84 at core_pc=4 (J, target 4) -> halt, cause=2, cycle_count frozen.
//  WDOG_LIMIT=10, program loops 0..2 -> halt after exactly 10 core_en cycles, cause=3.
//  HALT and breakpoint in same cycle -> cause=0; STEP from HALTED -> one core_en pulse, halted.
//  RUN while running -> cmd_err pulse, state unchanged; reset mid-RUN -> IDLE, core_en=0, no irq.

Source files
------------

// File: rtl/k2_pkg.sv
// Shared types and instruction field positions for the K2 execution controller.
package k2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_STEP,
      ST_HALTED
   } k2_ctrl_state_t;

   typedef enum logic [1:0] {
      OP_RUN  = 2'd0,
      OP_STEP = 2'd1,
      OP_HALT = 2'd2,
      OP_LOAD = 2'd3
   } k2_cmd_op_t;

   typedef enum logic [1:0] {
      HC_HOST     = 2'd0,
      HC_BREAK    = 2'd1,
      HC_SELFLOOP = 2'd2,
      HC_WDOG     = 2'd3
   } k2_halt_cause_t;

   localparam int K2_J_BIT   = 7;
   localparam int K2_IMM_MSB = 2;

endpackage

// File: rtl/k2_exec_ctrl_if.sv
// Host command port of the K2 execution controller (valid/ready plus error pulse).
interface k2_exec_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        cmd_data;
   logic              cmd_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data,
      input  cmd_ready, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data,
      output cmd_ready, cmd_err
   );
endinterface

// File: rtl/k2_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module k2_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   count <= '0;
      else if (clear)              count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
   end

endmodule

// File: rtl/k2_exec_ctrl.sv
// Run/step/halt sequencer for the K2 core: gates core_en, clears the core before a
// fresh run, writes program bytes and halts on host/breakpoint/self-loop/watchdog.
module k2_exec_ctrl
   import k2_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int CYC_W      = 16,
   parameter int WDOG_LIMIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   k2_exec_ctrl_if.slave     cmd,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [7:0]        imem_wdata,
   input  logic [ADDR_W-1:0] core_pc,
   input  logic [7:0]        core_instr,
   output logic              core_en,
   output logic              core_clear,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   output logic              running,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic              done_irq,
   output logic [CYC_W-1:0]  cycle_count
);

   k2_ctrl_state_t    state, state_nxt;
   k2_cmd_op_t        op, tgt, tgt_nxt;
   k2_halt_cause_t    cause, cause_nxt, stop_cause;
   logic              acc, stop, bp_skip, bp_hit, self_hit, wdog_hit;
   logic              err_nxt, we_nxt;
   logic [ADDR_W-1:0] imm;

   assign op            = k2_cmd_op_t'(cmd.cmd_op);
   assign cmd.cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
   assign acc           = cmd.cmd_valid && cmd.cmd_ready;

   assign imm      = ADDR_W'(core_instr[K2_IMM_MSB:0]);
   assign bp_hit   = bp_en && (core_pc == bp_addr) && !bp_skip;
   assign self_hit = core_instr[K2_J_BIT] && (imm == core_pc);
   assign wdog_hit = (WDOG_LIMIT != 0) && (cycle_count == CYC_W'(WDOG_LIMIT));

   assign running    = (state == ST_RUN);
   assign halted     = (state == ST_HALTED);
   assign halt_cause = cause;

   // Stop reasons in priority order; a stopping instruction is never executed.
   always_comb begin
      stop       = 1'b1;
      stop_cause = HC_HOST;
      if (acc && op == OP_HALT) stop_cause = HC_HOST;
      else if (bp_hit)          stop_cause = HC_BREAK;
      else if (self_hit)        stop_cause = HC_SELFLOOP;
      else if (wdog_hit)        stop_cause = HC_WDOG;
      else                      stop       = 1'b0;
   end

   always_comb begin
      state_nxt  = state;
      tgt_nxt    = tgt;
      cause_nxt  = cause;
      err_nxt    = 1'b0;
      we_nxt     = 1'b0;
      core_en    = 1'b0;
      core_clear = 1'b0;
      unique case (state)
         ST_IDLE: if (acc) begin
            case (op)
               OP_LOAD: we_nxt  = 1'b1;
               OP_HALT: err_nxt = 1'b1;
               default: begin
                  tgt_nxt   = op;
                  state_nxt = ST_CLEAR;
               end
            endcase
         end
         ST_CLEAR: begin
            core_clear = 1'b1;
            state_nxt  = (tgt == OP_STEP) ? ST_STEP : ST_RUN;
         end
         ST_RUN: begin
            core_en = !stop;
            err_nxt = acc && (op != OP_HALT);
            if (stop) begin
               state_nxt = ST_HALTED;
               cause_nxt = stop_cause;
            end
         end
         ST_STEP: begin
            core_en   = 1'b1;
            state_nxt = ST_HALTED;
            cause_nxt = HC_HOST;
         end
         ST_HALTED: if (acc) begin
            case (op)
               OP_RUN:  state_nxt = ST_RUN;
               OP_STEP: state_nxt = ST_STEP;
               OP_LOAD: begin
                  we_nxt    = 1'b1;
                  state_nxt = ST_IDLE;
               end
               default: err_nxt = 1'b1;
            endcase
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         tgt         <= OP_RUN;
         cause       <= HC_HOST;
         bp_skip     <= 1'b0;
         cmd.cmd_err <= 1'b0;
         done_irq    <= 1'b0;
         imem_we     <= 1'b0;
         imem_waddr  <= '0;
         imem_wdata  <= '0;
      end else begin
         state       <= state_nxt;
         tgt         <= tgt_nxt;
         cause       <= cause_nxt;
         // Resuming from HALTED lets the PC that hit the breakpoint execute once.
         bp_skip     <= (state == ST_HALTED) && acc && (op == OP_RUN);
         cmd.cmd_err <= err_nxt;
         done_irq    <= (state_nxt == ST_HALTED) && (state != ST_HALTED);
         imem_we     <= we_nxt;
         if (we_nxt) begin
            imem_waddr <= cmd.cmd_addr;
            imem_wdata <= cmd.cmd_data;
         end
      end
   end

   k2_sat_counter #(.W(CYC_W)) u_cyc (
      .clk   (clk),
      .reset (reset),
      .clear (state == ST_CLEAR),
      .inc   (core_en),
      .count (cycle_count)
   );

endmodule
